// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed 7-segment display controller.
// Holds the register offsets, the control register layout and reset value,
// and the active-low "all off" pin levels.
package seg7_pkg;

    // Register offsets relative to BASE_ADDR
    localparam int unsigned DIGIT_OFS = 0;

    function automatic int unsigned DPM_OFS(input int unsigned num_digits);
        return num_digits / 2;
    endfunction

    function automatic int unsigned CTRL_OFS(input int unsigned num_digits);
        return (num_digits / 2) + 1;
    endfunction

    // Control register bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_LZB_BIT    = 1;
    localparam int unsigned CTRL_BLINK_BIT  = 2;
    localparam int unsigned CTRL_RSVD_BIT   = 3;
    localparam int unsigned CTRL_BRIGHT_LSB = 4;
    localparam int unsigned CTRL_BRIGHT_W   = 4;

    // Control register layout, MSB first
    typedef struct packed {
        logic [CTRL_BRIGHT_W-1:0] bright;
        logic                     rsvd;
        logic                     blink;
        logic                     lzb;
        logic                     en;
    } ctrl_t;

    localparam logic [7:0] CTRL_RESET = 8'hF1;

    // Active-low off levels
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic       SEL_OFF = 1'b1;

endpackage

// File: rtl/seg7_hex_encoder.sv
// seg7_hex_encoder: combinational 0-F font, lowercase b and d.
// Ports: nibble (4-bit value in), seg_n_c (active-low segments g..a out, a = bit 0).
module seg7_hex_encoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n_c
);

    logic [6:0] seg_c;

    // Active-high font, then inverted for the common-anode pins
    always_comb begin
        seg_c = 7'h00;
        unique case (nibble)
            4'h0: seg_c = 7'h3F;
            4'h1: seg_c = 7'h06;
            4'h2: seg_c = 7'h5B;
            4'h3: seg_c = 7'h4F;
            4'h4: seg_c = 7'h66;
            4'h5: seg_c = 7'h6D;
            4'h6: seg_c = 7'h7D;
            4'h7: seg_c = 7'h07;
            4'h8: seg_c = 7'h7F;
            4'h9: seg_c = 7'h6F;
            4'hA: seg_c = 7'h77;
            4'hB: seg_c = 7'h7C;
            4'hC: seg_c = 7'h39;
            4'hD: seg_c = 7'h5E;
            4'hE: seg_c = 7'h79;
            4'hF: seg_c = 7'h71;
            default: seg_c = 7'h00;
        endcase
        seg_n_c = ~seg_c;
    end

endmodule

// File: rtl/seg7_mux_display.sv
// seg7_mux_display: bus-mapped multiplexed common-anode 7-segment controller.
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-low reset
//   BUS_ADDR/DATA  8-bit write bus, qualified by BUS_WE
//   SEG_SELECT_OUT active-low digit anodes, at most one low
//   SEG7_OUT       active-low segments {dp,g,f,e,d,c,b,a}
module seg7_mux_display
    import seg7_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'hD0,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned STROBE_MAX   = 99999,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned BLINK_SLOTS  = 512
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            BUS_ADDR,
    input  logic [7:0]            BUS_DATA,
    input  logic                  BUS_WE,
    output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
    output logic [7:0]            SEG7_OUT
);

    localparam int unsigned PAIRS   = NUM_DIGITS / 2;
    localparam int unsigned SLOT_W  = $clog2(STROBE_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam int unsigned STEP    = (STROBE_MAX + 1) >> 4;
    localparam int unsigned THR_W   = SLOT_W + 5;

    localparam logic [7:0] DIGIT_ADDR = 8'(int'(BASE_ADDR) + DIGIT_OFS);
    localparam logic [7:0] DPM_ADDR   = 8'(int'(BASE_ADDR) + DPM_OFS(NUM_DIGITS));
    localparam logic [7:0] CTRL_ADDR  = 8'(int'(BASE_ADDR) + CTRL_OFS(NUM_DIGITS));

    logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
    ctrl_t                      ctrl_q, ctrl_d;

    logic [SLOT_W-1:0]          slot_q, slot_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [BLINK_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                       blink_phase_q, blink_phase_d;

    logic [NUM_DIGITS-1:0]      sel_q, sel_d;
    logic [7:0]                 seg_q, seg_d;

    logic [3:0]                 nibble_c;
    logic [6:0]                 font_n_c;
    logic                       lead_zero_c;
    logic                       blanked_c;
    logic [THR_W-1:0]           thr_c;
    logic                       lit_c;
    logic                       unused_rsvd_c;

    // Reserved control bit is stored but drives nothing
    assign unused_rsvd_c = ctrl_q.rsvd;

    // Register writes; unmatched addresses and BUS_WE=0 leave state alone
    always_comb begin
        digit_d = digit_q;
        dp_d    = dp_q;
        ctrl_d  = ctrl_q;
        if (BUS_WE) begin
            for (int unsigned k = 0; k < PAIRS; k++) begin
                if (BUS_ADDR == 8'(int'(DIGIT_ADDR) + k)) begin
                    digit_d[2*k]   = BUS_DATA[3:0];
                    digit_d[2*k+1] = BUS_DATA[7:4];
                end
            end
            if (BUS_ADDR == DPM_ADDR) begin
                dp_d = BUS_DATA[NUM_DIGITS-1:0];
            end
            if (BUS_ADDR == CTRL_ADDR) begin
                ctrl_d = ctrl_t'(BUS_DATA);
            end
        end
    end

    // Slot counter, digit index and blink phase
    always_comb begin
        slot_d        = slot_q + SLOT_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_q == SLOT_W'(STROBE_MAX)) begin
            slot_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
                if (blink_cnt_q == BLINK_W'(BLINK_SLOTS - 1)) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    assign nibble_c = digit_q[idx_q];

    seg7_hex_encoder u_hex (
        .nibble  (nibble_c),
        .seg_n_c (font_n_c)
    );

    // Leading-zero run from the top digit down to idx; a set DP ends the run
    always_comb begin
        lead_zero_c = 1'b1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= 32'(idx_q)) && ((digit_q[j] != 4'h0) || dp_q[j])) begin
                lead_zero_c = 1'b0;
            end
        end
    end

    assign blanked_c = ctrl_q.lzb && (idx_q != '0) && lead_zero_c;
    assign thr_c     = (THR_W'(ctrl_q.bright) + THR_W'(1)) * THR_W'(STEP);

    assign lit_c = ctrl_q.en
                && (slot_q >= SLOT_W'(GUARD_CYCLES))
                && (THR_W'(slot_q) < thr_c)
                && !(ctrl_q.blink && blink_phase_q)
                && !blanked_c;

    // Pin values for the next clock; off unless the current digit is lit
    always_comb begin
        sel_d = {NUM_DIGITS{SEL_OFF}};
        seg_d = SEG_OFF;
        if (lit_c) begin
            sel_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = {~dp_q[idx_q], font_n_c};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            digit_q       <= '0;
            dp_q          <= '0;
            ctrl_q        <= ctrl_t'(CTRL_RESET);
            slot_q        <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sel_q         <= {NUM_DIGITS{SEL_OFF}};
            seg_q         <= SEG_OFF;
        end else begin
            digit_q       <= digit_d;
            dp_q          <= dp_d;
            ctrl_q        <= ctrl_d;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
        end
    end

    assign SEG_SELECT_OUT = sel_q;
    assign SEG7_OUT       = seg_q;

endmodule

// File: tb/tb_seg7_mux_display.sv
// tb_seg7_mux_display: directed self-checking bench for seg7_mux_display
// with NUM_DIGITS=4, STROBE_MAX=31, GUARD_CYCLES=2, BLINK_SLOTS=2.
module tb_seg7_mux_display;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] SEG7_OUT;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int onehot_bad = 0;

    seg7_mux_display #(
        .BASE_ADDR    (8'hD0),
        .NUM_DIGITS   (4),
        .STROBE_MAX   (31),
        .GUARD_CYCLES (2),
        .BLINK_SLOTS  (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .BUS_ADDR       (BUS_ADDR),
        .BUS_DATA       (BUS_DATA),
        .BUS_WE         (BUS_WE),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .SEG7_OUT       (SEG7_OUT)
    );

    always #5 CLK = ~CLK;

    // Clocks since reset release; pins after edge n reflect state index n-1
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Never two anodes low at once
    always @(negedge CLK) begin
        if (!$onehot0(~SEG_SELECT_OUT)) onehot_bad <= onehot_bad + 1;
    end

    function automatic logic [3:0] exp_sel(input int ix, input bit lit);
        logic [3:0] one;
        one = 4'b0001;
        return lit ? ~(one << ix) : 4'hF;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input logic we);
        @(negedge CLK);
        BUS_ADDR = a;
        BUS_DATA = d;
        BUS_WE   = we;
        @(negedge CLK);
        BUS_WE   = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset;
        RESET    = 1'b0;
        BUS_ADDR = 8'h00;
        BUS_DATA = 8'h00;
        BUS_WE   = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (50) @(negedge CLK);
        // state 49: slot 17, digit 1 showing "0"
        compared++;
        if (SEG_SELECT_OUT !== 4'b1101 || SEG7_OUT !== 8'hC0) begin
            mismatched++;
            $display("FAIL midscan: sel=%b seg=%h want sel=1101 seg=c0", SEG_SELECT_OUT, SEG7_OUT);
        end
        #2 RESET = 1'b0;
        #1;
        compared++;
        if (SEG_SELECT_OUT !== 4'hF || SEG7_OUT !== 8'hFF) begin
            mismatched++;
            $display("FAIL async_reset: sel=%b seg=%h want sel=1111 seg=ff", SEG_SELECT_OUT, SEG7_OUT);
        end
        repeat (3) @(negedge CLK);
        compared++;
        if (SEG_SELECT_OUT !== 4'hF || SEG7_OUT !== 8'hFF) begin
            mismatched++;
            $display("FAIL reset_hold: sel=%b seg=%h want sel=1111 seg=ff", SEG_SELECT_OUT, SEG7_OUT);
        end
        RESET = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge CLK);
            compared++;
            if (n < 3 && (SEG_SELECT_OUT !== 4'hF || SEG7_OUT !== 8'hFF)) begin
                mismatched++;
                $display("FAIL guard_after_release clk%0d: sel=%b seg=%h want sel=1111 seg=ff",
                         n, SEG_SELECT_OUT, SEG7_OUT);
            end else if (n == 3 && (SEG_SELECT_OUT !== 4'b1110 || SEG7_OUT !== 8'hC0)) begin
                mismatched++;
                $display("FAIL first_lit: sel=%b seg=%h want sel=1110 seg=c0", SEG_SELECT_OUT, SEG7_OUT);
            end
        end
    endtask

    task automatic test_digits;
        logic [7:0] pat [4];
        int s, sl, ix;
        bit lit;
        pat = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        bus_write(8'hD0, 8'h21, 1'b1);
        bus_write(8'hD1, 8'h43, 1'b1);
        for (int n = 0; n < 130; n++) begin
            @(negedge CLK);
            s = cyc - 1; sl = s % 32; ix = (s / 32) % 4;
            lit = (sl >= 2);
            compared++;
            if (SEG_SELECT_OUT !== exp_sel(ix, lit) || SEG7_OUT !== (lit ? pat[ix] : 8'hFF)) begin
                mismatched++;
                $display("FAIL digits slot%0d idx%0d: sel=%b seg=%h want sel=%b seg=%h",
                         sl, ix, SEG_SELECT_OUT, SEG7_OUT, exp_sel(ix, lit), lit ? pat[ix] : 8'hFF);
            end
        end
    endtask

    task automatic test_write_enable;
        logic [7:0] pat [4];
        bit on [4];
        int s, sl, ix;
        bit lit;
        // BUS_WE low and out-of-block addresses must not change anything
        bus_write(8'hD0, 8'hFF, 1'b0);
        bus_write(8'hD4, 8'hFF, 1'b1);
        bus_write(8'hCF, 8'hFF, 1'b1);
        pat = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        for (int n = 0; n < 128; n++) begin
            @(negedge CLK);
            s = cyc - 1; sl = s % 32; ix = (s / 32) % 4;
            lit = (sl >= 2);
            compared++;
            if (SEG_SELECT_OUT !== exp_sel(ix, lit) || SEG7_OUT !== (lit ? pat[ix] : 8'hFF)) begin
                mismatched++;
                $display("FAIL we_low slot%0d idx%0d: sel=%b seg=%h want sel=%b seg=%h",
                         sl, ix, SEG_SELECT_OUT, SEG7_OUT, exp_sel(ix, lit), lit ? pat[ix] : 8'hFF);
            end
        end
        // 0005 with DP on digit 2 and LZB: dark, "0.", "0", "5"
        bus_write(8'hD0, 8'h05, 1'b1);
        bus_write(8'hD1, 8'h00, 1'b1);
        bus_write(8'hD2, 8'h04, 1'b1);
        bus_write(8'hD3, 8'hF3, 1'b1);
        pat = '{8'h92, 8'hC0, 8'h40, 8'hFF};
        on  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int n = 0; n < 128; n++) begin
            @(negedge CLK);
            s = cyc - 1; sl = s % 32; ix = (s / 32) % 4;
            lit = (sl >= 2) && on[ix];
            compared++;
            if (SEG_SELECT_OUT !== exp_sel(ix, lit) || SEG7_OUT !== (lit ? pat[ix] : 8'hFF)) begin
                mismatched++;
                $display("FAIL lzb_dp slot%0d idx%0d: sel=%b seg=%h want sel=%b seg=%h",
                         sl, ix, SEG_SELECT_OUT, SEG7_OUT, exp_sel(ix, lit), lit ? pat[ix] : 8'hFF);
            end
        end
    endtask

    task automatic test_brightness;
        logic [7:0] pat [4];
        int s, sl, ix, lit_count;
        bit lit;
        // BRIGHT=0: window 2..1 is empty
        bus_write(8'hD3, 8'h01, 1'b1);
        for (int n = 0; n < 128; n++) begin
            @(negedge CLK);
            compared++;
            if (SEG_SELECT_OUT !== 4'hF || SEG7_OUT !== 8'hFF) begin
                mismatched++;
                $display("FAIL bright0 cyc%0d: sel=%b seg=%h want sel=1111 seg=ff", cyc, SEG_SELECT_OUT, SEG7_OUT);
            end
        end
        // BRIGHT=3, LZB off: lit for slot counts 2..7
        bus_write(8'hD3, 8'h31, 1'b1);
        pat = '{8'h92, 8'hC0, 8'h40, 8'hC0};
        lit_count = 0;
        for (int n = 0; n < 128; n++) begin
            @(negedge CLK);
            s = cyc - 1; sl = s % 32; ix = (s / 32) % 4;
            lit = (sl >= 2) && (sl < 8);
            if (SEG_SELECT_OUT !== 4'hF) lit_count++;
            compared++;
            if (SEG_SELECT_OUT !== exp_sel(ix, lit) || SEG7_OUT !== (lit ? pat[ix] : 8'hFF)) begin
                mismatched++;
                $display("FAIL bright3 slot%0d idx%0d: sel=%b seg=%h want sel=%b seg=%h",
                         sl, ix, SEG_SELECT_OUT, SEG7_OUT, exp_sel(ix, lit), lit ? pat[ix] : 8'hFF);
            end
        end
        compared++;
        if (lit_count !== 24) begin
            mismatched++;
            $display("FAIL bright3_lit_clocks: got %0d want 24", lit_count);
        end
    endtask

    task automatic test_blink;
        logic [7:0] pat [4];
        int s, sl, ix, ph;
        bit lit;
        bus_write(8'hD3, 8'hF5, 1'b1);
        pat = '{8'h92, 8'hC0, 8'h40, 8'hC0};
        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            s = cyc - 1; sl = s % 32; ix = (s / 32) % 4; ph = (s / 256) % 2;
            lit = (sl >= 2) && (ph == 0);
            compared++;
            if (SEG_SELECT_OUT !== exp_sel(ix, lit) || SEG7_OUT !== (lit ? pat[ix] : 8'hFF)) begin
                mismatched++;
                $display("FAIL blink s%0d phase%0d: sel=%b seg=%h want sel=%b seg=%h",
                         s, ph, SEG_SELECT_OUT, SEG7_OUT, exp_sel(ix, lit), lit ? pat[ix] : 8'hFF);
            end
        end
    endtask

    task automatic test_disable;
        bus_write(8'hD3, 8'hF0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            compared++;
            if (SEG_SELECT_OUT !== 4'hF || SEG7_OUT !== 8'hFF) begin
                mismatched++;
                $display("FAIL disabled cyc%0d: sel=%b seg=%h want sel=1111 seg=ff", cyc, SEG_SELECT_OUT, SEG7_OUT);
            end
        end
    endtask

    task automatic test_onehot;
        compared++;
        if (onehot_bad !== 0) begin
            mismatched++;
            $display("FAIL anode_onehot0: %0d bad cycles want 0", onehot_bad);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_write_enable();
        test_brightness();
        test_blink();
        test_disable();
        test_onehot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
